// File: rtl/sync_fifo_ctl_pkg.sv
// Shared types and helpers for the single-clock FIFO controller.
// Read-mode selector and pointer width derivation.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width; a one-bit pointer is kept even for degenerate depths.
    function automatic int ptr_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sync_fifo_ctl_if.sv
// Request/status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_ctl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             clearErr;
    logic             write;
    logic [WIDTH-1:0] writeData;
    logic             full;
    logic             almostFull;
    logic             read;
    logic [WIDTH-1:0] readData;
    logic             empty;
    logic             almostEmpty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, clearErr, write, writeData, read,
        input  full, almostFull, readData, empty, almostEmpty, count,
               overflow, underflow
    );

    modport slave (
        input  flush, clearErr, write, writeData, read,
        output full, almostFull, readData, empty, almostEmpty, count,
               overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ctl_wrap_ptr.sv
// Wrap-around pointer for a FIFO of arbitrary depth: counts 0..DEPTH-1 and
// returns to 0 by explicit compare, so non-power-of-two depths work.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 10
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          clr,
    input  logic                          inc,
    output logic [ptr_width(DEPTH)-1:0]   o_ptr
);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    // Next pointer: clear wins, otherwise advance with wrap at LAST.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (clr) begin
            w_ptr_nxt = {PW{1'b0}};
        end else if (inc) begin
            if (r_ptr == LAST) begin
                w_ptr_nxt = {PW{1'b0}};
            end else begin
                w_ptr_nxt = r_ptr + PW'(1);
            end
        end else begin
            w_ptr_nxt = r_ptr;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_ptr <= {PW{1'b0}};
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with any depth, registered or show-ahead read, fill level,
// almost-full/empty thresholds, sticky error flags and synchronous flush.
module sync_fifo_ctl
    import fifo_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter int         DEPTH    = 10,
    parameter fifo_mode_e MODE     = FIFO_STD,
    parameter int         AF_LEVEL = DEPTH - 2,
    parameter int         AE_LEVEL = 2
) (
    input  logic          clk,
    input  logic          rstN,
    sync_fifo_ctl_if.slave bus
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "sync_fifo_ctl: DEPTH must be at least 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $fatal(1, "sync_fifo_ctl: AF_LEVEL out of range 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > (DEPTH - 1))) begin : g_bad_ae
        $fatal(1, "sync_fifo_ctl: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             r_af;
    logic             r_ae;
    logic             r_ovf;
    logic             r_udf;
    logic [PW-1:0]    w_wr_ptr;
    logic [PW-1:0]    w_rd_ptr;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_ovf_set;
    logic             w_udf_set;

    // Flush drops both requests outright, so it never raises an error either.
    assign w_wr_acc  = bus.write && !r_full  && !bus.flush;
    assign w_rd_acc  = bus.read  && !r_empty && !bus.flush;
    assign w_ovf_set = bus.write &&  r_full  && !bus.flush;
    assign w_udf_set = bus.read  &&  r_empty && !bus.flush;

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rstN  (rstN),
        .clr   (bus.flush),
        .inc   (w_wr_acc),
        .o_ptr (w_wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rstN  (rstN),
        .clr   (bus.flush),
        .inc   (w_rd_acc),
        .o_ptr (w_rd_ptr)
    );

    // Next fill level.
    always_comb begin
        w_count_nxt = r_count;
        if (bus.flush) begin
            w_count_nxt = {CW{1'b0}};
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Fill level and flags, registered from the next count so they never glitch.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_count <= {CW{1'b0}};
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == {CW{1'b0}});
            r_af    <= (w_count_nxt >= CW'(AF_LEVEL));
            r_ae    <= (w_count_nxt <= CW'(AE_LEVEL));
        end
    end

    // Sticky errors; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set || (r_ovf && !bus.clearErr);
            r_udf <= w_udf_set || (r_udf && !bus.clearErr);
        end
    end

    // Storage array, intentionally without reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_ptr] <= bus.writeData;
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        logic [WIDTH-1:0] r_rd_data;

        // Registered read port: loads on an accepted read, holds otherwise.
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                r_rd_data <= {WIDTH{1'b0}};
            end else if (bus.flush) begin
                r_rd_data <= {WIDTH{1'b0}};
            end else if (w_rd_acc) begin
                r_rd_data <= r_mem[w_rd_ptr];
            end else begin
                r_rd_data <= r_rd_data;
            end
        end

        assign bus.readData = r_rd_data;
    end else begin : g_fwft
        assign bus.readData = r_empty ? {WIDTH{1'b0}} : r_mem[w_rd_ptr];
    end

    assign bus.count       = r_count;
    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
    assign bus.almostFull  = r_af;
    assign bus.almostEmpty = r_ae;
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_udf;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl: a DEPTH=10 registered-read instance and a
// DEPTH=10 show-ahead instance share clock and reset.
module tb_sync_fifo_ctl;
    import fifo_pkg::*;

    logic clk;
    logic rstN;
    int   n_run;
    int   n_fail;

    sync_fifo_ctl_if #(.WIDTH(8), .DEPTH(10)) bus_s ();
    sync_fifo_ctl_if #(.WIDTH(8), .DEPTH(10)) bus_f ();

    sync_fifo_ctl #(.WIDTH(8), .DEPTH(10), .MODE(FIFO_STD),
                    .AF_LEVEL(8), .AE_LEVEL(2)) u_std (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus_s)
    );

    sync_fifo_ctl #(.WIDTH(8), .DEPTH(10), .MODE(FIFO_FWFT),
                    .AF_LEVEL(8), .AE_LEVEL(2)) u_fwft (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] flags;
        flags = {bus_s.empty, bus_s.full, bus_s.almostEmpty, bus_s.almostFull,
                 bus_s.overflow, bus_s.underflow};
        n_run++;
        if (flags !== 6'b101000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 101000", flags);
        end
        n_run++;
        if ({bus_s.count, bus_s.readData, bus_f.readData} !== {4'd0, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_data: count %0d rd_std %h rd_fwft %h expected 0 00 00",
                     bus_s.count, bus_s.readData, bus_f.readData);
        end
    endtask

    task automatic test_fill_drain();
        logic [3:0] exp_cnt;
        for (int i = 1; i <= 10; i++) begin
            bus_s.write = 1'b1;
            bus_s.writeData = 8'(i);
            tick();
            exp_cnt = 4'(i);
            n_run++;
            if ({bus_s.count, bus_s.almostFull, bus_s.almostEmpty} !==
                {exp_cnt, (i >= 8), (i <= 2)}) begin
                n_fail++;
                $display("FAIL fill_%0d: count %0d af %b ae %b expected %0d %b %b", i,
                         bus_s.count, bus_s.almostFull, bus_s.almostEmpty,
                         exp_cnt, (i >= 8), (i <= 2));
            end
        end
        n_run++;
        if ({bus_s.full, bus_s.empty} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_at_10: full %b empty %b expected 1 0", bus_s.full, bus_s.empty);
        end
        bus_s.writeData = 8'hEE;
        tick();
        bus_s.write = 1'b0;
        n_run++;
        if ({bus_s.overflow, bus_s.count} !== {1'b1, 4'd10}) begin
            n_fail++;
            $display("FAIL overflow: ovf %b count %0d expected 1 10", bus_s.overflow, bus_s.count);
        end
        bus_s.clearErr = 1'b1;
        tick();
        bus_s.clearErr = 1'b0;
        n_run++;
        if (bus_s.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b expected 0", bus_s.overflow);
        end
        for (int k = 1; k <= 10; k++) begin
            bus_s.read = 1'b1;
            tick();
            exp_cnt = 4'(10 - k);
            n_run++;
            if ({bus_s.readData, bus_s.count, bus_s.almostEmpty, bus_s.almostFull} !==
                {8'(k), exp_cnt, ((10 - k) <= 2), ((10 - k) >= 8)}) begin
                n_fail++;
                $display("FAIL drain_%0d: data %h count %0d ae %b af %b expected %h %0d %b %b",
                         k, bus_s.readData, bus_s.count, bus_s.almostEmpty, bus_s.almostFull,
                         8'(k), exp_cnt, ((10 - k) <= 2), ((10 - k) >= 8));
            end
        end
        bus_s.read = 1'b0;
        tick();
        n_run++;
        if ({bus_s.empty, bus_s.readData} !== {1'b1, 8'h0A}) begin
            n_fail++;
            $display("FAIL std_hold: empty %b data %h expected 1 0a", bus_s.empty, bus_s.readData);
        end
    endtask

    task automatic test_underflow();
        bus_s.read = 1'b1;
        tick();
        n_run++;
        if ({bus_s.underflow, bus_s.readData} !== {1'b1, 8'h0A}) begin
            n_fail++;
            $display("FAIL underflow: udf %b data %h expected 1 0a", bus_s.underflow, bus_s.readData);
        end
        bus_s.clearErr = 1'b1;
        tick();
        n_run++;
        if (bus_s.underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clear: got %b expected 1", bus_s.underflow);
        end
        bus_s.read = 1'b0;
        tick();
        bus_s.clearErr = 1'b0;
        n_run++;
        if (bus_s.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL udf_clear: got %b expected 0", bus_s.underflow);
        end
    endtask

    task automatic test_back_to_back();
        bus_s.write = 1'b1;
        bus_s.writeData = 8'h80;
        tick();
        bus_s.read = 1'b1;
        for (int i = 0; i < 25; i++) begin
            bus_s.writeData = 8'(8'h81 + i);
            tick();
            n_run++;
            if ({bus_s.readData, bus_s.count} !== {8'(8'h80 + i), 4'd1}) begin
                n_fail++;
                $display("FAIL wrap_%0d: data %h count %0d expected %h 1", i,
                         bus_s.readData, bus_s.count, 8'(8'h80 + i));
            end
        end
        bus_s.write = 1'b0;
        tick();
        bus_s.read = 1'b0;
        n_run++;
        if ({bus_s.readData, bus_s.empty, bus_s.underflow} !== {8'h99, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_last: data %h empty %b udf %b expected 99 1 0",
                     bus_s.readData, bus_s.empty, bus_s.underflow);
        end
    endtask

    task automatic test_flush();
        bus_s.write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_s.writeData = 8'(8'h11 + i);
            tick();
        end
        bus_s.flush = 1'b1;
        bus_s.read = 1'b1;
        tick();
        bus_s.flush = 1'b0;
        bus_s.read = 1'b0;
        bus_s.writeData = 8'h33;
        n_run++;
        if ({bus_s.count, bus_s.empty, bus_s.overflow, bus_s.underflow, bus_s.readData} !==
            {4'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL flush: count %0d empty %b ovf %b udf %b data %h expected 0 1 0 0 00",
                     bus_s.count, bus_s.empty, bus_s.overflow, bus_s.underflow, bus_s.readData);
        end
        tick();
        bus_s.write = 1'b0;
        bus_s.read = 1'b1;
        tick();
        bus_s.read = 1'b0;
        n_run++;
        if ({bus_s.readData, bus_s.empty} !== {8'h33, 1'b1}) begin
            n_fail++;
            $display("FAIL post_flush: data %h empty %b expected 33 1", bus_s.readData, bus_s.empty);
        end
    endtask

    task automatic test_fwft();
        bus_f.write = 1'b1;
        bus_f.writeData = 8'h5A;
        tick();
        bus_f.write = 1'b0;
        n_run++;
        if ({bus_f.empty, bus_f.readData} !== {1'b0, 8'h5A}) begin
            n_fail++;
            $display("FAIL fwft_show: empty %b data %h expected 0 5a", bus_f.empty, bus_f.readData);
        end
        bus_f.read = 1'b1;
        tick();
        bus_f.read = 1'b0;
        n_run++;
        if ({bus_f.empty, bus_f.readData} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL fwft_pop: empty %b data %h expected 1 00", bus_f.empty, bus_f.readData);
        end
        bus_f.write = 1'b1;
        bus_f.writeData = 8'h11;
        tick();
        bus_f.writeData = 8'h22;
        tick();
        bus_f.write = 1'b0;
        bus_f.read = 1'b1;
        n_run++;
        if ({bus_f.readData, bus_f.count} !== {8'h11, 4'd2}) begin
            n_fail++;
            $display("FAIL fwft_head: data %h count %0d expected 11 2", bus_f.readData, bus_f.count);
        end
        tick();
        n_run++;
        if ({bus_f.readData, bus_f.count} !== {8'h22, 4'd1}) begin
            n_fail++;
            $display("FAIL fwft_next: data %h count %0d expected 22 1", bus_f.readData, bus_f.count);
        end
        tick();
        bus_f.read = 1'b0;
    endtask

    task automatic test_async_reset();
        bus_s.write = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus_s.writeData = 8'(8'hA0 + i);
            tick();
        end
        bus_s.write = 1'b0;
        n_run++;
        if ({bus_s.full, bus_s.overflow} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset: full %b ovf %b expected 1 1", bus_s.full, bus_s.overflow);
        end
        #2;
        rstN = 1'b0;
        #1;
        n_run++;
        if ({bus_s.empty, bus_s.full, bus_s.almostEmpty, bus_s.almostFull, bus_s.overflow,
             bus_s.underflow, bus_s.count, bus_s.readData} !==
            {6'b101000, 4'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL async_reset: flags %b%b%b%b%b%b count %0d data %h expected 101000 0 00",
                     bus_s.empty, bus_s.full, bus_s.almostEmpty, bus_s.almostFull,
                     bus_s.overflow, bus_s.underflow, bus_s.count, bus_s.readData);
        end
        @(negedge clk);
        rstN = 1'b1;
        tick();
        n_run++;
        if ({bus_s.empty, bus_s.count} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL after_reset: empty %b count %0d expected 1 0", bus_s.empty, bus_s.count);
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        rstN = 1'b0;
        bus_s.flush = 1'b0; bus_s.clearErr = 1'b0; bus_s.write = 1'b0;
        bus_s.read = 1'b0;  bus_s.writeData = 8'h00;
        bus_f.flush = 1'b0; bus_f.clearErr = 1'b0; bus_f.write = 1'b0;
        bus_f.read = 1'b0;  bus_f.writeData = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        tick();
        test_reset();
        test_fill_drain();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_fwft();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
